dffre_pipe: RTL and testbench

- Parametrised successor to the single-bit enabled flip-flop primitive: a WIDTH-bit, DEPTH-stage pipeline register with a global enable and synchronous active-high reset.
- Adds a valid/ready handshake per transfer with bubble-collapsing backpressure, so it can be dropped between fabric blocks as a retiming or elastic stage.
- Sits in the same simulation-model library as the flip-flop primitives.

---
 rtl/dffre_pipe.sv | 144 ++++++++++++++
 tb/tb_dffre_pipe.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/dffre_pipe.sv
// -----------------------------------------------------------------------------
// dffre_pipe
//   WIDTH-bit, DEPTH-stage elastic pipeline register. It has a global enable,
//   a synchronous active-high reset, and a valid/ready handshake with
//   bubble-collapsing backpressure.
//
//   Ports
//     C   in   1      clock, all state updates on posedge
//     R   in   1      synchronous active-high reset; overrides E and handshakes
//     E   in   1      global enable; while low every register holds and
//                     DR/QV are forced low
//     D   in   WIDTH  input data, sampled only on an input transfer (DV & DR)
//     DV  in   1      input valid
//     DR  out  1      input ready
//     Q   out  WIDTH  output data (last stage)
//     QV  out  1      output valid
//     QR  in   1      output ready; an output transfer is QV & QR
//     OCC out  $clog2(DEPTH+1)  number of occupied stages. This port exists
//                     only when DFFRE_PIPE_OCC_EN is defined.
//
//   Optional feature macro: DFFRE_PIPE_OCC_EN adds the OCC port.
//
//   Integration note: the ready chain is combinational. A path runs from QR
//   to DR, so a stage can pop and push in the same cycle.
// -----------------------------------------------------------------------------
module dffre_pipe #(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 2,
    parameter int               RESET_DATA = 1,
    parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b0}}
) (
    input  logic             C,
    input  logic             R,
    input  logic             E,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    output logic             DR,
    output logic [WIDTH-1:0] Q,
    output logic             QV,
    input  logic             QR
`ifdef DFFRE_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] OCC
`endif
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // The power-up contents match the reset contents.
    logic [DEPTH-1:0] v_q = {DEPTH{1'b0}};
    logic [WIDTH-1:0] d_q [DEPTH] = '{default: RESET_VAL};

    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] rdy_s;
    logic             run_s;

    assign run_s = E & ~R;
    assign DR    = run_s & rdy_s[0];
    assign QV    = run_s & v_q[DEPTH-1];
    assign Q     = d_q[DEPTH-1];

    // Ready chain: a stage can accept when it is empty or some later stage
    // can make room. The chain is built as a running OR from the tail, so
    // any bubble downstream unblocks every stage upstream of it.
    always_comb begin
        logic acc_v;
        acc_v = QR;
        rdy_s = {DEPTH{1'b0}};
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc_v    = acc_v | ~v_q[k];
            rdy_s[k] = acc_v;
        end
    end

    // Next-state shift. A ready stage takes its upstream valid bit. Data
    // moves only with a valid item, so bubbles never disturb held data.
    always_comb begin
        v_d = v_q;
        for (int k = 0; k < DEPTH; k++) begin
            d_d[k] = d_q[k];
        end
        if (E) begin
            if (rdy_s[0]) begin
                v_d[0] = DV;
                if (DV) begin
                    d_d[0] = D;
                end else begin
                    d_d[0] = d_q[0];
                end
            end else begin
                v_d[0] = v_q[0];
                d_d[0] = d_q[0];
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (rdy_s[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end else begin
                        d_d[k] = d_q[k];
                    end
                end else begin
                    v_d[k] = v_q[k];
                    d_d[k] = d_q[k];
                end
            end
        end else begin
            v_d = v_q;
        end
    end

    // State registers. Reset clears every valid bit. The data registers
    // either load RESET_VAL or keep their contents, depending on RESET_DATA.
    always_ff @(posedge C) begin
        if (R) begin
            v_q <= {DEPTH{1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                if (RESET_DATA != 0) begin
                    d_q[k] <= RESET_VAL;
                end else begin
                    d_q[k] <= d_q[k];
                end
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

`ifdef DFFRE_PIPE_OCC_EN
    // Occupancy popcount. It does not depend on E, so it shows the held
    // count while the pipe is frozen.
    always_comb begin
        OCC = {OCC_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            OCC = OCC + OCC_W'(v_q[k]);
        end
    end
`endif

endmodule

// File: tb/tb_dffre_pipe.sv
module tb_dffre_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;

    logic       C  = 1'b0;
    logic       R  = 1'b1;
    logic       E  = 1'b1;
    logic       DV = 1'b0;
    logic       QR = 1'b0;
    logic [7:0] D  = 8'h00;
    logic       DR;
    logic       QV;
    logic [7:0] Q;
`ifdef DFFRE_PIPE_OCC_EN
    logic [1:0] OCC;
`endif

    dffre_pipe #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_DATA(1), .RESET_VAL(8'h00)
    ) dut (
        .C(C), .R(R), .E(E), .D(D), .DV(DV), .DR(DR),
        .Q(Q), .QV(QV), .QR(QR)
`ifdef DFFRE_PIPE_OCC_EN
        , .OCC(OCC)
`endif
    );

    always #5 C = ~C;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } item_t;

    item_t exp_q[$];
    int    tests     = 0;
    int    fails     = 0;
    int    cyc_n     = 0;
    bit    exp_dr    = 1'b0;
    bit    exact_lat = 1'b0;
    int    cnt;
    item_t it;

    always @(posedge C) cyc_n <= cyc_n + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Monitor: the model is an ordered queue of items in flight.
    // DR = E & !R & (items < DEPTH | QR); QV is low when frozen, in reset or empty.
    always @(negedge C) begin
        cnt    = exp_q.size();
        exp_dr = E && !R && ((cnt < DEPTH) || QR);
        check("DR", int'(DR), int'(exp_dr));
        if (!E || R || cnt == 0) check("QV_low", int'(QV), 0);
`ifdef DFFRE_PIPE_OCC_EN
        check("OCC", int'(OCC), cnt);
`endif
        if (QV && QR) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %0h expected no output", Q);
            end else begin
                it = exp_q.pop_front();
                check("Q_data", int'(Q), int'(it.data));
                if (exact_lat) check("latency", cyc_n - it.cyc, DEPTH);
                else           check("latency_min", int'(cyc_n - it.cyc >= DEPTH), 1);
            end
        end
        if (R) exp_q.delete();
    end

    // Drive one cycle of inputs. An accepted input is recorded as expected output.
    task automatic cyc(input bit e, input bit r, input bit dv, input logic [7:0] d, input bit qr);
        @(posedge C);
        #1;
        E = e; R = r; DV = dv; D = d; QR = qr;
        @(negedge C);
        #1;
        if (dv && exp_dr) exp_q.push_back('{data: d, cyc: cyc_n});
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int nxt;
        // Reset with junk on the input side
        cyc(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_Q", int'(Q), 8'h00);
        check("rst_QV", int'(QV), 0);
        check("rst_DR", int'(DR), 1);

        // Stream: exact latency, no gaps
        exact_lat = 1'b1;
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
        drain();
        exact_lat = 1'b0;

        // Backpressure, then a simultaneous pop and push
        cyc(1'b1, 1'b0, 1'b1, 8'h10, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h12, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("bp_DR", int'(DR), 0);
        check("bp_Q", int'(Q), 8'h10);
        check("bp_QV", int'(QV), 1);
        cyc(1'b1, 1'b0, 1'b1, 8'h13, 1'b1);
        check("bp_pushpop_DR", int'(DR), 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("bp_next_Q", int'(Q), 8'h11);
`ifdef DFFRE_PIPE_OCC_EN
        check("bp_OCC", int'(OCC), 3);
`endif
        drain();

        // Bubble collapse
        cyc(1'b1, 1'b0, 1'b1, 8'h20, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h21, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("bub_DR", int'(DR), 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("bub_Q0", int'(Q), 8'h20);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        check("bub_Q1", int'(Q), 8'h21);
        check("bub_QV1", int'(QV), 1);
        drain();

        // Enable freeze mid-stream
        nxt = 8'h30;
        for (int i = 0; i < 16; i++) begin
            cyc(!(i >= 4 && i < 8), 1'b0, nxt <= 8'h37, 8'(nxt), 1'b1);
            if (nxt <= 8'h37 && exp_dr) nxt++;
        end
        check("freeze_all_sent", nxt, 8'h38);
        drain();

        // Reset mid-flight
        cyc(1'b1, 1'b0, 1'b1, 8'h40, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h41, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h42, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h43, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        check("mrst_QV", int'(QV), 0);
        check("mrst_Q", int'(Q), 8'h00);
        check("mrst_DR", int'(DR), 1);
        drain();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 8) != 0, ($urandom % 64) == 0, $urandom % 2,
                8'($urandom), ($urandom % 3) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
